// File: rtl/shift_unit.sv
// Multicycle shifter: picks one of NSRC operand sources, then performs a logical,
// arithmetic or rotate shift of up to STEP bit positions per clock until the
// requested amount is consumed. Start/done handshake toward the control unit.
module shift_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 3,
   parameter int unsigned SEL_W = 2,
   parameter int unsigned STEP  = 1
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       start_i,
   input  logic [SEL_W-1:0]           src_sel_i,
   input  logic [NSRC*WIDTH-1:0]      src_data_i,
   input  logic [$clog2(WIDTH)-1:0]   shamt_i,
   input  logic [2:0]                 op_i,
   output logic [WIDTH-1:0]           result_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       sel_err_o
);

   localparam int unsigned ShW = $clog2(WIDTH);

   localparam logic [2:0] OpLoad = 3'b000;
   localparam logic [2:0] OpSll  = 3'b001;
   localparam logic [2:0] OpSrl  = 3'b010;
   localparam logic [2:0] OpSra  = 3'b011;
   localparam logic [2:0] OpRol  = 3'b100;
   localparam logic [2:0] OpRor  = 3'b101;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] result_q;
   logic [2:0]       op_q;
   logic [ShW-1:0]   rem_q;
   logic             busy_q;
   logic             done_q;
   logic             sel_err_q;

   logic [WIDTH-1:0] sel_data;
   logic             sel_bad;
   logic             is_load;
   logic [ShW-1:0]   step_k;
   logic [ShW-1:0]   rot_k;
   logic [WIDTH-1:0] shifted;

   // Operand source mux; out-of-range selects yield zero and raise the error flag.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (src_sel_i == SEL_W'(i)) begin
            sel_data = src_data_i[i*WIDTH +: WIDTH];
         end
      end
      sel_bad = (32'(src_sel_i) >= NSRC);
      // Codes 110 and 111 behave as LOAD.
      is_load = (op_i == OpLoad) || (op_i[2:1] == 2'b11);
   end

   // Per-cycle shift distance k = min(STEP, rem) and the shifted working value.
   always_comb begin
      if ({1'b0, rem_q} <= (ShW+1)'(STEP)) begin
         step_k = rem_q;
      end else begin
         step_k = ShW'(STEP);
      end
      // Complementary rotate distance WIDTH-k; only used while k is non-zero.
      rot_k = ShW'(0) - step_k;
      unique case (op_q)
         OpSll:   shifted = result_q << step_k;
         OpSrl:   shifted = result_q >> step_k;
         OpSra:   shifted = unsigned'($signed(result_q) >>> step_k);
         OpRol:   shifted = (result_q << step_k) | (result_q >> rot_k);
         OpRor:   shifted = (result_q >> step_k) | (result_q << rot_k);
         default: shifted = result_q;
      endcase
   end

   // Control FSM with registered result and status outputs.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q   <= StIdle;
         result_q  <= '0;
         op_q      <= OpLoad;
         rem_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  result_q  <= sel_bad ? '0 : sel_data;
                  sel_err_q <= sel_bad;
                  op_q      <= op_i;
                  rem_q     <= shamt_i;
                  if (is_load || (shamt_i == '0)) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StShift;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= StIdle;
               end
            end
            StShift: begin
               result_q <= shifted;
               rem_q    <= rem_q - step_k;
               if (rem_q == step_k) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign result_o  = result_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: drivers push expected responses, per-DUT
// monitors pop and compare on every done pulse. Two instances: STEP=1 and STEP=4.
module tb_shift_unit;

   localparam logic [2:0] OpLoad = 3'b000;
   localparam logic [2:0] OpSll  = 3'b001;
   localparam logic [2:0] OpSrl  = 3'b010;
   localparam logic [2:0] OpSra  = 3'b011;
   localparam logic [2:0] OpRol  = 3'b100;
   localparam logic [2:0] OpRor  = 3'b101;

   typedef struct {
      logic [31:0] res;
      logic        err;
      int          lat;
      int          nb;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start1, start4;
   logic [1:0]  src_sel;
   logic [95:0] src_data;
   logic [4:0]  shamt;
   logic [2:0]  op;
   logic [31:0] res1, res4;
   logic        busy1, busy4, done1, done4, err1, err4;

   exp_t q1[$];
   exp_t q4[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   bc1    = 0;
   int   bc4    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   shift_unit #(.WIDTH(32), .NSRC(3), .SEL_W(2), .STEP(1)) u_dut1 (
      .clk_i(clk), .reset_ni(reset_n), .start_i(start1), .src_sel_i(src_sel),
      .src_data_i(src_data), .shamt_i(shamt), .op_i(op), .result_o(res1),
      .busy_o(busy1), .done_o(done1), .sel_err_o(err1)
   );

   shift_unit #(.WIDTH(32), .NSRC(3), .SEL_W(2), .STEP(4)) u_dut4 (
      .clk_i(clk), .reset_ni(reset_n), .start_i(start4), .src_sel_i(src_sel),
      .src_data_i(src_data), .shamt_i(shamt), .op_i(op), .result_o(res4),
      .busy_o(busy4), .done_o(done4), .sel_err_o(err4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_done(input string tag, input exp_t e, input logic [31:0] r,
                             input logic err, input logic busy, input int bc);
      chk({tag, "_result"}, r, e.res);
      chk({tag, "_sel_err"}, 32'(err), 32'(e.err));
      chk({tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      chk({tag, "_busy_cycles"}, 32'(bc), 32'(e.nb));
      chk({tag, "_busy_with_done"}, 32'(busy), 32'd0);
   endtask

   // Monitor for the STEP=1 instance.
   always @(negedge clk) begin
      exp_t e;
      if (done1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1_unexpected_done: got done=1, required done=0");
         end else begin
            e = q1.pop_front();
            check_done("dut1", e, res1, err1, busy1, bc1);
         end
         bc1 = 0;
      end else if (busy1) begin
         bc1++;
      end else begin
         bc1 = 0;
      end
   end

   // Monitor for the STEP=4 instance.
   always @(negedge clk) begin
      exp_t e;
      if (done4) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut4_unexpected_done: got done=1, required done=0");
         end else begin
            e = q4.pop_front();
            check_done("dut4", e, res4, err4, busy4, bc4);
         end
         bc4 = 0;
      end else if (busy4) begin
         bc4++;
      end else begin
         bc4 = 0;
      end
   end

   // Drive one request; the expectation is queued with the cycle it is presented in.
   task automatic issue(input bit d4, input bit at_neg, input logic [95:0] sd,
                        input logic [1:0] sel, input logic [2:0] o, input logic [4:0] sh,
                        input logic [31:0] er, input logic ee, input int lat, input int nb,
                        input bit push);
      exp_t e;
      if (!at_neg) @(negedge clk);
      src_data = sd;
      src_sel  = sel;
      op       = o;
      shamt    = sh;
      if (d4) start4 = 1'b1;
      else    start1 = 1'b1;
      if (push) begin
         e.res = er;
         e.err = ee;
         e.lat = lat;
         e.nb  = nb;
         e.acc = cyc;
         if (d4) q4.push_back(e);
         else    q1.push_back(e);
      end
      @(posedge clk);
      #1;
      start1   = 1'b0;
      start4   = 1'b0;
      // Post-accept source changes must not disturb the operation.
      src_data = {3{32'h5A5A_C3C3}};
   endtask

   task automatic drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         #2;
         if (q1.size() == 0 && q4.size() == 0 && !busy1 && !busy4) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_drain: got pending=%0d/%0d, required 0/0", name, q1.size(),
                  q4.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset_n  = 1'b0;
      start1   = 1'b0;
      start4   = 1'b0;
      src_sel  = '0;
      src_data = '0;
      shamt    = '0;
      op       = OpLoad;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", res1, 32'h0);
      chk("reset_busy", 32'(busy1), 32'h0);
      chk("reset_done", 32'(done1), 32'h0);
      chk("reset_sel_err", 32'(err1), 32'h0);
      chk("reset_result4", res4, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      issue(0, 0, {32'h1234_5678, 32'h0, 32'h1}, 2'd0, OpSll, 5'd4, 32'h10, 0, 5, 4, 1);
      drain("sll4");
      issue(0, 0, {32'h1234_5678, 32'h8000_0000, 32'h1}, 2'd1, OpSra, 5'd31,
            32'hFFFF_FFFF, 0, 32, 31, 1);
      drain("sra31");
      issue(0, 0, {32'h1234_5678, 32'h8000_0000, 32'h1}, 2'd1, OpSrl, 5'd31,
            32'h1, 0, 32, 31, 1);
      drain("srl31");
      issue(0, 0, {32'h1234_5678, 32'h0, 32'h0}, 2'd2, OpRor, 5'd8, 32'h7812_3456, 0, 9, 8, 1);
      drain("ror8");
      issue(0, 0, {32'h1234_5678, 32'h0, 32'h0}, 2'd2, OpRol, 5'd4, 32'h2345_6781, 0, 5, 4, 1);
      drain("rol4");
      issue(0, 0, {32'h1234_5678, 32'h0, 32'h0}, 2'd2, OpSll, 5'd0, 32'h1234_5678, 0, 1, 0, 1);
      drain("shamt0");
      issue(0, 0, {32'h0, 32'hDEAD_BEEF, 32'h0}, 2'd1, OpLoad, 5'd5, 32'hDEAD_BEEF, 0, 1, 0, 1);
      drain("load");
      issue(0, 0, {32'h0, 32'h0, 32'hA5A5_A5A5}, 2'd0, 3'b110, 5'd7, 32'hA5A5_A5A5, 0, 1, 0, 1);
      drain("op110");
      issue(0, 0, {32'h0, 32'h0, 32'hF000_0010}, 2'd0, OpSra, 5'd4, 32'hFF00_0001, 0, 5, 4, 1);
      drain("sra4");
      issue(0, 0, {32'h1, 32'h2, 32'h3}, 2'd3, OpLoad, 5'd0, 32'h0, 1, 1, 0, 1);
      drain("sel3_load");
      repeat (3) @(negedge clk);
      chk("sel_err_held", 32'(err1), 32'h1);
      issue(0, 0, {32'h1, 32'h2, 32'h3}, 2'd3, OpSll, 5'd2, 32'h0, 1, 3, 2, 1);
      drain("sel3_sll");
      issue(0, 0, {32'h0, 32'h0, 32'h80}, 2'd0, OpSrl, 5'd3, 32'h10, 0, 4, 3, 1);
      drain("sel_err_clear");
      repeat (3) @(negedge clk);
      chk("result_held_idle", res1, 32'h10);

      // STEP=4: steps of 4,4,2 with a start pulse during SHIFT that must be ignored.
      issue(1, 0, {32'h0, 32'h0, 32'hF000_0000}, 2'd0, OpSrl, 5'd10, 32'h003C_0000, 0, 4, 3, 1);
      @(negedge clk);
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      drain("step4_srl10");
      issue(1, 0, {32'h1234_5678, 32'h0, 32'h0}, 2'd2, OpRol, 5'd31, 32'h091A_2B3C, 0, 9, 8, 1);
      drain("step4_rol31");

      // Reset mid-SHIFT aborts without a done pulse.
      issue(0, 0, {32'h0, 32'h0, 32'hFFFF_FFFF}, 2'd0, OpSll, 5'd20, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_result", res1, 32'h0);
      chk("abort_busy", 32'(busy1), 32'h0);
      chk("abort_done", 32'(done1), 32'h0);
      chk("abort_sel_err", 32'(err1), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (25) @(negedge clk);

      // Back-to-back: second start presented in the DONE cycle of the first.
      issue(0, 0, {32'h1234_5678, 32'h0, 32'h1}, 2'd0, OpSll, 5'd3, 32'h8, 0, 4, 3, 1);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (done1) seen = 1'b1;
      end
      chk("b2b_first_done_seen", 32'(seen), 32'h1);
      issue(0, 1, {32'h1234_5678, 32'h0, 32'h1}, 2'd2, OpSrl, 5'd4, 32'h0123_4567, 0, 5, 4, 1);
      drain("b2b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised multicycle shifter that selects one of `NSRC` operand sources, then performs a logical, arithmetic or rotate shift over several clock cycles. It sits in the datapath after the register file and the immediate extender and feeds the result mux. The control unit starts it with a start/done handshake. It extends the combinational shift-source select with an out-of-range select flag, a configurable step per cycle, and a registered result.

## Interface
- `WIDTH`, 32: data width in bits; a power of two ≥ 4.
- `NSRC`, 3: number of operand sources; ≥ 2.
- `SEL_W`, 2: select width; must satisfy 2^SEL_W ≥ NSRC.
- `STEP`, 1: maximum shift distance per cycle; a power of two, 1..WIDTH.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `start`  in  1: request; sampled only when the block is idle (IDLE or DONE).
- `src_sel`  in  SEL_W: operand source index, sampled with `start`.
- `src_data`  in  NSRC*WIDTH: flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- `shamt`  in  log2(WIDTH): shift amount, sampled with `start`.
- `op`  in  3: operation, sampled with `start`. Encodings: 000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; 110 and 111 are treated as LOAD.
- `result`  out  WIDTH: working/result register.
- `busy`  out  1: high while in the SHIFT state.
- `done`  out  1: one-cycle pulse; `result` is final while `done` is high.
- `sel_err`  out  1: set when the accepted `src_sel` is ≥ NSRC; held until the next accepted start.

## Operation
- States are IDLE, SHIFT and DONE. Reset forces IDLE and clears every output: `result`=0, `busy`=0, `done`=0, `sel_err`=0.
- **Accept.** `start`=1 in IDLE or DONE:
  - `result` ← `src_data[src_sel]`; if `src_sel` ≥ NSRC, `result` ← 0 and `sel_err` ← 1, otherwise `sel_err` ← 0.
  - The operation is latched; the remaining count `rem` ← `shamt`.
  - If `op` is LOAD or `shamt`=0, the next state is DONE; otherwise it is SHIFT.
- **SHIFT.** Each cycle, let k = min(STEP, rem):
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: fill with the sign bit (`result[WIDTH-1]`).
  - ROL/ROR: bits wrap around.
  - `rem` ← `rem` − k. When `rem` reaches 0 in this update, the next state is DONE.
- **DONE.** `done`=1 for exactly one cycle. The next state is IDLE, unless `start`=1, which is accepted as a new request (back-to-back).
- **Hold.** `start` in SHIFT is ignored and not queued. `result` holds its value in IDLE and DONE until the next accept. `src_data` changes after the accept have no effect.
- **Arithmetic.** All shifts are modulo WIDTH. `shamt` is unsigned, 0..WIDTH−1. Results are truncated to WIDTH bits.

## Timing
- Accept at edge T. For SHIFT operations `busy`=1 from T+1, and the last shift is at edge T+ceil(shamt/STEP).
- `done` is high from edge T+1+ceil(shamt/STEP) for one cycle; `busy` is low in that cycle.
- For LOAD or `shamt`=0, `done` is high from edge T+1.
- Back-to-back: a `start` in the DONE cycle is accepted at that cycle's closing edge. The next `done` comes ceil(shamt/STEP)+1 cycles later, with no idle bubble.
- Reset has priority over everything at any edge, including mid-SHIFT. There is no `done` pulse for an aborted operation, and the block is in IDLE on the next cycle.
- `busy` and `done` are never high together.

## Test plan
- WIDTH=32, STEP=1: SLL of src0=0x0000_0001, `shamt`=4, accept at T → `busy` high for cycles T+1..T+4. Then `done` at T+5 with `result`=0x0000_0010.
- SRA of src1=0x8000_0000, `shamt`=31 → `result`=0xFFFF_FFFF with `done` 32 cycles after accept. SRL of the same value by 31 gives 0x0000_0001.
- ROR of src2=0x1234_5678 by 8 → 0x7812_3456. ROL of the same value by 4 → 0x2345_6781.
- `shamt`=0, and separately `op`=LOAD with `src_sel`=1 holding 0xDEAD_BEEF → `done` at T+1 with `result`=0xDEAD_BEEF and `busy` never high. Then `src_sel`=3 (NSRC=3) → `result`=0 and `sel_err`=1.
- STEP=4: SRL of 0xF000_0000 by 10 → shift steps of 4, 4 and 2; `done` at T+4 with `result`=0x003C_0000. A `start` pulsed at T+2 is ignored.
- `reset`=0 at T+3 during a 20-cycle SLL → all outputs 0 at T+4 with no `done` pulse. Then a back-to-back start in the DONE cycle of a following operation → the next `done` comes exactly ceil(shamt/STEP)+1 cycles later.
